// File: rtl/key_mode_ctrl.sv
// Key front-end for the LED chaser: synchronises and debounces three buttons,
// steps the 2-bit pattern select, and generates a pausable step-enable pulse.
module key_mode_ctrl #(
    parameter int DB_CYCLES  = 20,
    parameter int DIV_CYCLES = 8,
    parameter int DB_W       = 20,
    parameter int DIV_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_next,
    input  logic       key_prev,
    input  logic       key_pause,
    output logic [1:0] sel,
    output logic       step_en,
    output logic       mode_chg,
    output logic       paused
);

    localparam int NK        = 3;
    localparam int KEY_NEXT  = 0;
    localparam int KEY_PREV  = 1;
    localparam int KEY_PAUSE = 2;

    logic [NK-1:0]    key_raw;
    logic [NK-1:0]    press;
    logic [1:0]       sel_reg;
    logic             step_en_reg;
    logic             mode_chg_reg;
    logic             paused_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       sel_fwd;
    logic [1:0]       sel_back;
    logic             sel_step;

    assign key_raw = {key_pause, key_prev, key_next};

    genvar gi;
    generate
        for (gi = 0; gi < NK; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    // Level only moves after DB_CYCLES consecutive mismatching samples.
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == DB_W'(DB_CYCLES - 1)) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= '0;
                            press_reg <= ~sync2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + DB_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    always_comb begin
        sel_fwd  = 2'b00;
        sel_back = 2'b00;
        case (sel_reg)
            2'b00: begin sel_fwd = 2'b01; sel_back = 2'b10; end
            2'b01: begin sel_fwd = 2'b10; sel_back = 2'b00; end
            2'b10: begin sel_fwd = 2'b00; sel_back = 2'b01; end
            default: begin sel_fwd = 2'b00; sel_back = 2'b00; end
        endcase
    end

    // Simultaneous next and prev cancel each other out.
    assign sel_step = press[KEY_NEXT] ^ press[KEY_PREV];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_reg      <= 2'b00;
            step_en_reg  <= 1'b0;
            mode_chg_reg <= 1'b0;
            paused_reg   <= 1'b0;
            div_cnt_reg  <= '0;
        end else begin
            mode_chg_reg <= sel_step;
            if (sel_step) begin
                sel_reg <= press[KEY_NEXT] ? sel_fwd : sel_back;
            end
            if (press[KEY_PAUSE]) begin
                paused_reg <= ~paused_reg;
            end
            // A mode change restarts the step period from zero.
            if (sel_step) begin
                div_cnt_reg <= '0;
                step_en_reg <= 1'b0;
            end else if (paused_reg) begin
                step_en_reg <= 1'b0;
            end else begin
                step_en_reg <= (div_cnt_reg == DIV_W'(DIV_CYCLES - 1));
                if (div_cnt_reg == DIV_W'(DIV_CYCLES - 1)) begin
                    div_cnt_reg <= '0;
                end else begin
                    div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                end
            end
        end
    end

    assign sel      = sel_reg;
    assign step_en  = step_en_reg;
    assign mode_chg = mode_chg_reg;
    assign paused   = paused_reg;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with DB_CYCLES=4, DIV_CYCLES=8; outputs are
// sampled 1 time unit after each rising edge.
module tb_key_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_next = 1'b1;
    logic       key_prev = 1'b1;
    logic       key_pause = 1'b1;
    logic [1:0] sel;
    logic       step_en;
    logic       mode_chg;
    logic       paused;

    int n_total = 0;
    int n_pass  = 0;
    int step_cnt = 0;
    int mc_cnt   = 0;
    int mc0;
    int s0;

    key_mode_ctrl #(
        .DB_CYCLES (4),
        .DIV_CYCLES(8),
        .DB_W      (20),
        .DIV_W     (24)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .key_next (key_next),
        .key_prev (key_prev),
        .key_pause(key_pause),
        .sel      (sel),
        .step_en  (step_en),
        .mode_chg (mode_chg),
        .paused   (paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (step_en)  step_cnt++;
            if (mode_chg) mc_cnt++;
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_next = v;
            1: key_prev = v;
            default: key_pause = v;
        endcase
    endtask

    task automatic press_key(input int k, input int hold, input int gap);
        set_key(k, 1'b0);
        tick(hold);
        set_key(k, 1'b1);
        tick(gap);
    endtask

    task automatic wait_step(input string tag);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!step_en && n < 20);
        check(tag, int'(step_en), 1);
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel", int'(sel), 0);
        check("rst_step_en", int'(step_en), 0);
        check("rst_mode_chg", int'(mode_chg), 0);
        check("rst_paused", int'(paused), 0);
        tick(3);
        rst_n = 1'b1;

        // Idle: step_en every 8 cycles, first after edge 8
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            check($sformatf("idle_step_%0d", i), int'(step_en), int'(i % 8 == 0));
        end
        check("idle_mc_cnt", mc_cnt, 0);
        check("idle_sel", int'(sel), 0);
        check("idle_paused", int'(paused), 0);

        // key_next press latency and hold
        mc0 = mc_cnt;
        key_next = 1'b0;
        tick(6);
        check("next1_e6_sel", int'(sel), 0);
        check("next1_e6_mc", int'(mode_chg), 0);
        tick(1);
        check("next1_e7_sel", int'(sel), 1);
        check("next1_e7_mc", int'(mode_chg), 1);
        tick(1);
        check("next1_e8_mc", int'(mode_chg), 0);
        tick(22);
        key_next = 1'b1;
        tick(8);
        check("next1_hold_sel", int'(sel), 1);
        check("next1_hold_mc", mc_cnt - mc0, 1);
        press_key(0, 10, 8);
        check("next2_sel", int'(sel), 2);
        press_key(0, 10, 8);
        check("next3_wrap_sel", int'(sel), 0);
        check("next_mc_total", mc_cnt - mc0, 3);

        // prev, glitch, simultaneous
        mc0 = mc_cnt;
        press_key(1, 10, 8);
        check("prev_sel", int'(sel), 2);
        check("prev_mc", mc_cnt - mc0, 1);
        key_next = 1'b0;
        tick(3);
        key_next = 1'b1;
        tick(10);
        check("glitch_sel", int'(sel), 2);
        check("glitch_mc", mc_cnt - mc0, 1);
        key_next = 1'b0;
        key_prev = 1'b0;
        tick(10);
        key_next = 1'b1;
        key_prev = 1'b1;
        tick(8);
        check("both_sel", int'(sel), 2);
        check("both_mc", mc_cnt - mc0, 1);

        // Pause: freezes at count 1, resumes 7 cycles after unpause
        wait_step("pre_pause_step");
        tick(2);
        key_pause = 1'b0;
        tick(6);
        check("pause_e6", int'(paused), 0);
        tick(1);
        check("pause_e7", int'(paused), 1);
        s0 = step_cnt;
        tick(3);
        key_pause = 1'b1;
        tick(47);
        check("paused_no_step", step_cnt - s0, 0);
        check("paused_level", int'(paused), 1);
        key_pause = 1'b0;
        tick(6);
        check("unpause_e6", int'(paused), 1);
        tick(1);
        check("unpause_e7", int'(paused), 0);
        check("unpause_e7_step", int'(step_en), 0);
        tick(6);
        check("resume_no_early_step", step_cnt - s0, 0);
        tick(1);
        check("resume_step", int'(step_en), 1);
        key_pause = 1'b1;
        tick(7);
        check("resume_gap", int'(step_en), 0);
        tick(1);
        check("resume_period", int'(step_en), 1);

        // Mode change at divider count 5 restarts the period
        wait_step("pre_chg_step");
        tick(7);
        key_next = 1'b0;
        tick(6);
        check("chg_e6_sel", int'(sel), 2);
        tick(1);
        check("chg_e7_sel", int'(sel), 0);
        check("chg_e7_mc", int'(mode_chg), 1);
        check("chg_e7_step", int'(step_en), 0);
        key_next = 1'b1;
        s0 = step_cnt;
        tick(7);
        check("chg_no_old_step", step_cnt - s0, 0);
        tick(1);
        check("chg_first_step", int'(step_en), 1);
        tick(8);

        // Reset mid-debounce with key_next held
        press_key(0, 10, 8);
        check("pre_rst_sel", int'(sel), 1);
        press_key(2, 10, 8);
        check("pre_rst_paused", int'(paused), 1);
        key_next = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", int'(sel), 0);
        check("mid_rst_paused", int'(paused), 0);
        check("mid_rst_step", int'(step_en), 0);
        check("mid_rst_mc", int'(mode_chg), 0);
        tick(2);
        check("mid_rst_hold_sel", int'(sel), 0);
        rst_n = 1'b1;
        mc0 = mc_cnt;
        tick(6);
        check("post_rst_e6_sel", int'(sel), 0);
        tick(1);
        check("post_rst_e7_sel", int'(sel), 1);
        check("post_rst_e7_mc", int'(mode_chg), 1);
        tick(20);
        check("post_rst_single_mc", mc_cnt - mc0, 1);
        key_next = 1'b1;
        tick(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_mode_ctrl.md
Name: key_mode_ctrl

Overview:
- Front-end controller for the 8-LED chaser.
- Debounces three raw push-buttons and turns their presses into the chaser's 2-bit pattern select (`sel`).
- Also generates the chaser's step-enable pulse, and can freeze it with a pause toggle.
- Sits between the board keys and the chaser on the same clock.

Parameters:
DB_CYCLES, 20, consecutive stable synchronised samples required to accept a key level change (board build: 1000000)
DIV_CYCLES, 8, clock cycles per step_en pulse (board build: 12000000); must be >= 2
DB_W, 20, debounce counter width; must hold DB_CYCLES-1
DIV_W, 24, divider counter width; must hold DIV_CYCLES-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
key_next  input  1  raw button, active-low, asynchronous to clk
key_prev  input  1  raw button, active-low, asynchronous to clk
key_pause  input  1  raw button, active-low, asynchronous to clk
sel  output  2  pattern select to chaser: 00, 01 or 10 (11 never driven)
step_en  output  1  one-cycle pulse, advance chaser one step
mode_chg  output  1  one-cycle pulse, sel changed this cycle
paused  output  1  level, step_en suppressed while high

Behaviour:
- Reset (rst low, asynchronous assert; release synchronous to clk via normal flop timing):
  - Outputs: sel=00, step_en=0, mode_chg=0, paused=0.
  - Internal: sync flops=1, debounced levels=1, debounce counters=0, divider=0, press strobes=0.
- Synchroniser: each key passes through 2 flops, reset value 1.
- Debounce, per key, independent:
  - If synced != debounced level, counter increments; otherwise counter clears.
  - When counter==DB_CYCLES-1 and a mismatch is still seen, level takes the synced value and counter clears.
  - A 1->0 level change sets that key's registered press strobe for exactly one cycle. 0->1 (release) produces no strobe.
  - Any glitch shorter than DB_CYCLES synced samples has no effect.
- Latency: number as edge 1 the first rising edge that samples a raw key low, with the key held low throughout.
  - Level flips and strobe registers at edge DB_CYCLES+2.
  - sel/paused update at edge DB_CYCLES+3; mode_chg is high for the cycle after that edge.
- Holding a key produces exactly one action. The next action requires a debounced release, then a new press.
- Mode sequencing on press strobes:
  - next only: sel 00->01->10->00 (wraps).
  - prev only: sel 00->10->01->00 (wraps).
  - next and prev strobes in the same cycle: sel unchanged, no mode_chg.
  - A pause strobe toggles paused. It is processed independently of, and concurrently with, next/prev.
- mode_chg: high exactly one cycle per actual sel change, aligned with the new sel value.
- Step divider:
  - Counter runs 0..DIV_CYCLES-1 and wraps to 0.
  - step_en is registered: high for the one cycle after the counter holds DIV_CYCLES-1 while paused=0.
  - paused=1: counter frozen, step_en=0. Unpausing resumes from the frozen count.
  - On any sel change the counter clears to 0 at the same edge, so the first step in a new mode comes DIV_CYCLES cycles later. A step_en pulse that would coincide with that edge is suppressed.
- Steady state: step_en period is exactly DIV_CYCLES cycles.
- Reset mid-operation (during debounce, pause, or mid-divide) returns everything to reset values. A key still held low after release must re-debounce fully and then yield exactly one action.

Test Plan (DB_CYCLES=4, DIV_CYCLES=8):
- Reset release, keys high, run 40 cycles -> sel=00, paused=0, mode_chg never high, step_en high once every 8 cycles (first after 8 cycles).
- key_next low from edge 1, held 30 cycles -> sel=01 and mode_chg pulse after edge 7. Then release, press again -> 10. Third press -> 00 (wrap). Exactly one mode_chg per press.
- key_prev press from sel=00 -> sel=10. key_next low for 3 cycles only (glitch) -> no change. key_next and key_prev pressed on the same edge -> sel unchanged, no mode_chg.
- key_pause press -> paused=1 after edge 7, no step_en for 50 cycles. Second press -> paused=0, step_en resumes from frozen count, then period 8.
- sel change at divider count 5 -> divider cleared, next step_en exactly 8 cycles after the mode_chg edge, no step_en at old count-7 position.
- rst pulled low mid-debounce (counter=2) with key_next held -> all outputs reset. After release, sel=01 at edge 7 counted from release, a single mode_chg.
